// File: rtl/chg_inc_sched_if.sv
// Request/grant/result bundle for chg_inc_sched; the master side belongs to the requesters
// and the slave side to the scheduler.
`timescale 1ns/1ps
interface chg_inc_sched_if #(
   parameter int NREQ = 4,
   parameter int W    = 32
);
   logic [NREQ-1:0]   req;
   logic [NREQ*W-1:0] op;
   logic [NREQ*3-1:0] steps;
   logic [NREQ-1:0]   gnt;
   logic              done;
   logic [2:0]        done_id;
   logic [W-1:0]      result;
   logic              busy;
   logic [15:0]       busy_cycles;

   modport master (
      output req, op, steps,
      input  gnt, done, done_id, result, busy, busy_cycles
   );

   modport slave (
      input  req, op, steps,
      output gnt, done, done_id, result, busy, busy_cycles
   );
endinterface

// File: rtl/chg_inc_sched.sv
// Round-robin scheduler time-sharing one W-bit +1 incrementer among NREQ requesters.
// Define CHG_INC_SCHED_BUSYCNT_EN to enable the saturating busy-cycle counter.
`timescale 1ns/1ps
module chg_inc_sched #(
   parameter int NREQ = 4,
   parameter int W    = 32
) (
   input  logic           clk,
   input  logic           reset,
   chg_inc_sched_if.slave bus
);
   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_e;

   state_e          state_q, state_d;
   logic [2:0]      ptr_q, ptr_d;
   logic [W-1:0]    acc_q, acc_d;
   logic [2:0]      cnt_q, cnt_d;
   logic [2:0]      id_q, id_d;
   logic [NREQ-1:0] gnt_q, gnt_d;
   logic            done_q, done_d;
   logic [2:0]      done_id_q, done_id_d;
   logic [W-1:0]    result_q, result_d;
   logic            busy_q, busy_d;

   logic            sel_found;
   int              sel_int;
   int              sel_dist;
   int              cand_dist;
   logic [NREQ-1:0] sel_onehot;
   logic [W-1:0]    sel_op;
   logic [2:0]      sel_steps;

   // Winner is the set request with the smallest upward distance from ptr (wrapping).
   always_comb begin : arb
      sel_found  = 1'b0;
      sel_int    = 0;
      sel_dist   = NREQ;
      cand_dist  = 0;
      sel_onehot = '0;
      sel_op     = '0;
      sel_steps  = '0;
      for (int i = 0; i < NREQ; i++) begin
         cand_dist = i - int'(ptr_q);
         if (cand_dist < 0) cand_dist = cand_dist + NREQ;
         if (bus.req[i] && (cand_dist < sel_dist)) begin
            sel_found     = 1'b1;
            sel_int       = i;
            sel_dist      = cand_dist;
            sel_onehot    = '0;
            sel_onehot[i] = 1'b1;
            sel_op        = bus.op[i*W +: W];
            sel_steps     = bus.steps[i*3 +: 3];
         end
      end
   end

   always_ff @(posedge clk) begin : state_reg
      if (reset) begin
         state_q   <= IDLE;
         ptr_q     <= '0;
         acc_q     <= '0;
         cnt_q     <= '0;
         id_q      <= '0;
         gnt_q     <= '0;
         done_q    <= 1'b0;
         done_id_q <= '0;
         result_q  <= '0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         acc_q     <= acc_d;
         cnt_q     <= cnt_d;
         id_q      <= id_d;
         gnt_q     <= gnt_d;
         done_q    <= done_d;
         done_id_q <= done_id_d;
         result_q  <= result_d;
         busy_q    <= busy_d;
      end
   end

   always_comb begin : next_state
      state_d = state_q;
      case (state_q)
         IDLE: if (sel_found) state_d = (sel_steps == 3'd0) ? DONE : RUN;
         RUN:  if (cnt_q == 3'd1) state_d = DONE;
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Outputs are registered, so they are computed from the state being entered.
   always_comb begin : out_logic
      ptr_d     = ptr_q;
      acc_d     = acc_q;
      cnt_d     = cnt_q;
      id_d      = id_q;
      gnt_d     = '0;
      done_d    = 1'b0;
      done_id_d = done_id_q;
      result_d  = result_q;
      busy_d    = (state_d != IDLE);
      case (state_q)
         IDLE: begin
            if (sel_found) begin
               acc_d = sel_op;
               cnt_d = sel_steps;
               id_d  = 3'(sel_int);
               gnt_d = sel_onehot;
               ptr_d = (sel_int == NREQ - 1) ? 3'd0 : 3'(sel_int + 1);
            end
         end
         RUN: begin
            acc_d = acc_q + W'(1);
            cnt_d = cnt_q - 3'd1;
         end
         default: ;
      endcase
      if (state_d == DONE) begin
         done_d    = 1'b1;
         result_d  = acc_d;
         done_id_d = id_d;
      end
   end

   assign bus.gnt     = gnt_q;
   assign bus.done    = done_q;
   assign bus.done_id = done_id_q;
   assign bus.result  = result_q;
   assign bus.busy    = busy_q;

`ifdef CHG_INC_SCHED_BUSYCNT_EN
   logic [15:0] bcnt_q, bcnt_d;

   always_comb begin
      bcnt_d = bcnt_q;
      if (busy_q && (bcnt_q != 16'hFFFF)) bcnt_d = bcnt_q + 16'd1;
   end

   always_ff @(posedge clk) begin
      if (reset) bcnt_q <= '0;
      else       bcnt_q <= bcnt_d;
   end

   assign bus.busy_cycles = bcnt_q;
`else
   assign bus.busy_cycles = 16'h0000;
`endif
endmodule

// File: tb/tb_chg_inc_sched.sv
// Bench for chg_inc_sched: directed scenarios plus randomized traffic against a
// cycle-accounting reference model (grant at accept+1, done k later, free k+2 after accept).
`timescale 1ns/1ps
module tb_chg_inc_sched;
  localparam int NREQ = 4;
  localparam int W    = 32;

  logic clk = 1'b0;
  logic reset;

  chg_inc_sched_if #(.NREQ(NREQ), .W(W)) bus ();

  chg_inc_sched #(.NREQ(NREQ), .W(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  logic         req_a [NREQ];
  logic [W-1:0] op_a  [NREQ];
  logic [2:0]   st_a  [NREQ];

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      bus.req[i]           = req_a[i];
      bus.op[i*W +: W]     = op_a[i];
      bus.steps[i*3 +: 3]  = st_a[i];
    end
  end

  int n_chk = 0;
  int n_err = 0;

  // reference model state
  int              cyc, free_at, gnt_cyc, done_cyc, m_ptr, m_bcnt;
  logic [NREQ-1:0] m_gvec;
  logic [W-1:0]    m_result, pend_res;
  logic [2:0]      m_id, pend_id;
  bit              exp_busy_cur;
  bit              rand_mode, persist;

  // observations for directed scenarios
  int           obs_gnt_cnt, obs_gnt_cyc, obs_done_cnt, obs_done_cyc;
  logic [W-1:0] obs_res;
  logic [2:0]   obs_id;
  int           gnt_log[$];
  int           gcyc_log[$];

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic bit bit_of(input logic [NREQ-1:0] v, input int i);
    logic [NREQ-1:0] t;
    t = v >> i;
    return t[0];
  endfunction

  function automatic int log_at(input int k);
    if (k < gnt_log.size()) return gnt_log[k];
    return 99;
  endfunction

  function automatic int gcyc_at(input int k);
    if (k < gcyc_log.size()) return gcyc_log[k];
    return -1000 * (k + 1);
  endfunction

  // Decide what the inputs now on the bus cause at the coming clock edge.
  task automatic commit();
    int pick, idx, k;
    pick = -1;
    if (reset) begin
      m_ptr    = 0;
      gnt_cyc  = -1;
      done_cyc = -1;
      free_at  = cyc + 1;
      m_result = '0;
      m_id     = '0;
      m_bcnt   = 0;
    end else begin
      if (exp_busy_cur && m_bcnt < 65535) m_bcnt++;
      if (cyc >= free_at) begin
        for (int off = 0; off < NREQ; off++) begin
          idx = (m_ptr + off) % NREQ;
          if (pick < 0 && req_a[idx]) pick = idx;
        end
        if (pick >= 0) begin
          k        = int'(st_a[pick]);
          gnt_cyc  = cyc + 1;
          done_cyc = cyc + 1 + k;
          pend_res = op_a[pick] + W'(k);
          pend_id  = 3'(pick);
          m_gvec   = NREQ'(1) << pick;
          free_at  = cyc + k + 2;
          m_ptr    = (pick + 1) % NREQ;
        end
      end
    end
  endtask

  task automatic check_outputs();
    bit              exp_done;
    logic [NREQ-1:0] exp_gnt;
    exp_done = (cyc == done_cyc);
    if (exp_done) begin
      m_result = pend_res;
      m_id     = pend_id;
    end
    exp_gnt      = (cyc == gnt_cyc) ? m_gvec : '0;
    exp_busy_cur = (gnt_cyc >= 0) && (cyc >= gnt_cyc) && (cyc <= done_cyc);
    chk("gnt",     64'(bus.gnt),     64'(exp_gnt));
    chk("done",    64'(bus.done),    64'(exp_done));
    chk("result",  64'(bus.result),  64'(m_result));
    chk("done_id", 64'(bus.done_id), 64'(m_id));
    chk("busy",    64'(bus.busy),    64'(exp_busy_cur));
`ifdef CHG_INC_SCHED_BUSYCNT_EN
    chk("busy_cycles", 64'(bus.busy_cycles), 64'(m_bcnt));
`else
    chk("busy_cycles", 64'(bus.busy_cycles), 64'h0);
`endif
    if (bus.gnt != '0) begin
      obs_gnt_cnt++;
      obs_gnt_cyc = cyc;
      for (int i = 0; i < NREQ; i++) if (bit_of(bus.gnt, i)) gnt_log.push_back(i);
      gcyc_log.push_back(cyc);
    end
    if (bus.done) begin
      obs_done_cnt++;
      obs_done_cyc = cyc;
      obs_res      = bus.result;
      obs_id       = bus.done_id;
    end
  endtask

  task automatic post_drive();
    for (int i = 0; i < NREQ; i++) begin
      if (bit_of(bus.gnt, i) && !persist) begin
        req_a[i] = 1'b0;
        if (rand_mode) begin
          op_a[i] = $urandom;
          st_a[i] = 3'($urandom_range(0, 7));
        end
      end
    end
    if (rand_mode) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!req_a[i] && $urandom_range(0, 3) == 0) begin
          req_a[i] = 1'b1;
          op_a[i]  = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFFF - 32'($urandom_range(0, 7)))
                                                 : 32'($urandom);
          st_a[i]  = 3'($urandom_range(0, 7));
        end
      end
      reset = ($urandom_range(0, 299) == 0);
    end
  endtask

  task automatic cycle();
    commit();
    @(negedge clk);
    cyc++;
    check_outputs();
    post_drive();
  endtask

  task automatic clear_obs();
    obs_gnt_cnt  = 0;
    obs_done_cnt = 0;
    obs_gnt_cyc  = -200;
    obs_done_cyc = -100;
    obs_res      = 'x;
    obs_id       = 'x;
    gnt_log.delete();
    gcyc_log.delete();
  endtask

  task automatic do_reset();
    for (int i = 0; i < NREQ; i++) req_a[i] = 1'b0;
    reset = 1'b1;
    cycle();
    cycle();
    reset = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench timed out");
  end

  initial begin
    reset = 1'b1;
    cyc = 0; free_at = 0; gnt_cyc = -1; done_cyc = -1; m_ptr = 0; m_bcnt = 0;
    m_gvec = '0; m_result = '0; m_id = '0; pend_res = '0; pend_id = '0;
    exp_busy_cur = 1'b0; rand_mode = 1'b0; persist = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      req_a[i] = 1'b0; op_a[i] = '0; st_a[i] = '0;
    end
    clear_obs();
    do_reset();

    // single job, three increments
    clear_obs();
    req_a[0] = 1'b1; op_a[0] = 32'h1111; st_a[0] = 3'd3;
    repeat (10) cycle();
    chk("t30_gnt_cnt", 64'(obs_gnt_cnt), 64'd1);
    chk("t30_gnt_id",  64'(log_at(0)), 64'd0);
    chk("t30_latency", 64'(obs_done_cyc - obs_gnt_cyc), 64'd3);
    chk("t30_result",  64'(obs_res), 64'h1114);
    chk("t30_done_id", 64'(obs_id), 64'd0);

    // wrap of all-ones
    clear_obs();
    req_a[1] = 1'b1; op_a[1] = 32'hFFFF_FFFF; st_a[1] = 3'd1;
    repeat (8) cycle();
    chk("t31_gnt_id",  64'(log_at(0)), 64'd1);
    chk("t31_latency", 64'(obs_done_cyc - obs_gnt_cyc), 64'd1);
    chk("t31_result",  64'(obs_res), 64'h0);
    chk("t31_done_id", 64'(obs_id), 64'd1);

    // zero steps: done alongside gnt
    clear_obs();
    req_a[2] = 1'b1; op_a[2] = 32'd5; st_a[2] = 3'd0;
    repeat (6) cycle();
    chk("t32_gnt_id",  64'(log_at(0)), 64'd2);
    chk("t32_latency", 64'(obs_done_cyc - obs_gnt_cyc), 64'd0);
    chk("t32_result",  64'(obs_res), 64'd5);
    chk("t32_done_id", 64'(obs_id), 64'd2);

    // all requesters held: round-robin order and spacing
    do_reset();
    clear_obs();
    persist = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      req_a[i] = 1'b1; op_a[i] = 32'(i * 16); st_a[i] = 3'd1;
    end
    repeat (16) cycle();
    for (int k = 0; k < 5; k++) chk("t33_order", 64'(log_at(k)), 64'(k % NREQ));
    for (int k = 1; k < 5; k++) chk("t33_spacing", 64'(gcyc_at(k) - gcyc_at(k - 1)), 64'd3);
    persist = 1'b0;
    do_reset();

    // reset mid-job abandons it and restarts arbitration at index 0
    clear_obs();
    persist = 1'b1;
    req_a[3] = 1'b1; op_a[3] = 32'd100; st_a[3] = 3'd7;
    for (int n = 0; n < 10 && obs_gnt_cnt == 0; n++) cycle();
    chk("t34_gnt3", 64'(log_at(0)), 64'd3);
    req_a[0] = 1'b1; op_a[0] = 32'd7; st_a[0] = 3'd2;
    cycle();
    cycle();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    chk("t34_busy",   64'(bus.busy), 64'd0);
    chk("t34_nodone", 64'(obs_done_cnt), 64'd0);
    clear_obs();
    repeat (6) cycle();
    chk("t34_next_gnt", 64'(log_at(0)), 64'd0);
    persist = 1'b0;
    do_reset();

    // busy-cycle counter over one steps=4 job
    clear_obs();
    req_a[0] = 1'b1; op_a[0] = 32'd0; st_a[0] = 3'd4;
    repeat (10) cycle();
`ifdef CHG_INC_SCHED_BUSYCNT_EN
    chk("t35_busy_cycles", 64'(bus.busy_cycles), 64'd5);
`else
    chk("t35_busy_cycles", 64'(bus.busy_cycles), 64'd0);
`endif
    chk("t35_result", 64'(obs_res), 64'd4);

    // randomized traffic with occasional resets
    rand_mode = 1'b1;
    repeat (3000) cycle();
    rand_mode = 1'b0;
    reset = 1'b0;
    repeat (12) cycle();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
